// File: rtl/apb_gpio_irq_queue.sv
// APB interrupt event queue for the GPIO block's per-pin interrupt vector.
// Rising edges on masked lines set per-pin pending bits. A round-robin scanner
// moves one pending pin ID per cycle into a FIFO. irq_o is asserted while the
// FIFO holds entries and the block is enabled. Software pops IDs over APB.
module apb_gpio_irq_queue #(
    parameter int APB_ADDR_WIDTH = 12,
    parameter int N_GPIO         = 32,
    parameter int FIFO_DEPTH     = 8
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    input  logic [APB_ADDR_WIDTH-1:0] PADDR,
    input  logic [31:0]               PWDATA,
    input  logic                      PWRITE,
    input  logic                      PSEL,
    input  logic                      PENABLE,
    output logic [31:0]               PRDATA,
    output logic                      PREADY,
    output logic                      PSLVERR,
    input  logic [N_GPIO-1:0]         interrupt_i,
    output logic                      irq_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;

    // state
    logic [N_GPIO-1:0] mask_r;
    logic [N_GPIO-1:0] pending_r;
    logic [N_GPIO-1:0] int_q_r;
    logic              enable_r;
    logic              overflow_r;
    logic              irq_r;
    logic [6:0]        rr_ptr_r;
    logic [6:0]        fifo_mem_r [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [CW-1:0]     count_r;

    // combinational
    logic [11:0]         addr_s;
    logic                acc_s, wr_s, rd_s;
    logic [63:0]         mask64_s, pend64_s, new_mask64_s;
    logic                mask_wr_s, pop_s, push_s, flush_s, full_s, empty_s;
    logic                ovf_set_s, ovf_clr_s, found_s;
    logic [2*N_GPIO-1:0] dbl_s;
    logic [N_GPIO-1:0]   rot_s, edge_s, push_vec_s, pending_n_s;
    logic [6:0]          off_s, sel_s, rr_next_s, head_s;
    logic [7:0]          sum_s;
    logic                unused_s;

    assign addr_s    = PADDR[11:0];
    assign acc_s     = PSEL & PENABLE;
    assign wr_s      = acc_s & PWRITE;
    assign rd_s      = acc_s & ~PWRITE;
    assign mask64_s  = 64'(mask_r);
    assign pend64_s  = 64'(pending_r);
    assign full_s    = (count_r == CW'(FIFO_DEPTH));
    assign empty_s   = (count_r == {CW{1'b0}});
    assign head_s    = fifo_mem_r[rd_ptr_r];
    assign edge_s    = interrupt_i & ~int_q_r & mask_r;
    assign pop_s     = rd_s & (addr_s == 12'h008) & ~empty_s;
    assign push_s    = found_s & ~full_s;
    assign flush_s   = wr_s & (addr_s == 12'h018) & PWDATA[1];
    assign ovf_clr_s = wr_s & (addr_s == 12'h00C) & PWDATA[0];
    assign ovf_set_s = |(edge_s & pending_r & ~push_vec_s);
    assign rr_next_s = (sel_s == 7'(N_GPIO - 1)) ? 7'd0 : (sel_s + 7'd1);
    assign PREADY    = 1'b1;
    assign PSLVERR   = 1'b0;
    assign irq_o     = irq_r;
    assign unused_s  = ^{new_mask64_s, dbl_s, PADDR};

    // Round-robin scan: rotate pending so rr_ptr sits at bit 0, take the lowest set bit.
    always_comb begin
        dbl_s = {pending_r, pending_r} >> rr_ptr_r;
        rot_s = dbl_s[N_GPIO-1:0];
        off_s = 7'd0;
        for (int j = N_GPIO - 1; j >= 0; j--) begin
            off_s = rot_s[j] ? 7'(j) : off_s;
        end
        found_s = |rot_s;
        sum_s   = {1'b0, rr_ptr_r} + {1'b0, off_s};
        sel_s   = (sum_s >= 8'(N_GPIO)) ? 7'(sum_s - 8'(N_GPIO)) : sum_s[6:0];
    end

    // One-hot of the pin being pushed this cycle.
    always_comb begin
        push_vec_s = {N_GPIO{1'b0}};
        for (int i = 0; i < N_GPIO; i++) begin
            push_vec_s[i] = push_s & (sel_s == 7'(i));
        end
    end

    // Mask write decode; the new mask also filters pending in the same cycle.
    always_comb begin
        new_mask64_s = mask64_s;
        mask_wr_s    = 1'b0;
        if (wr_s) begin
            case (addr_s)
                12'h000: begin
                    new_mask64_s[31:0] = PWDATA;
                    mask_wr_s          = 1'b1;
                end
                12'h004: begin
                    new_mask64_s[63:32] = PWDATA;
                    mask_wr_s           = 1'b1;
                end
                default: mask_wr_s = 1'b0;
            endcase
        end else begin
            mask_wr_s = 1'b0;
        end
    end

    // Next pending: pushed pin clears, a new edge sets (even on its push cycle), unmasking clears.
    always_comb begin
        pending_n_s = (pending_r & ~push_vec_s) | edge_s;
        if (mask_wr_s) begin
            pending_n_s = pending_n_s & new_mask64_s[N_GPIO-1:0];
        end else begin
            pending_n_s = pending_n_s;
        end
    end

    // APB read mux, driven only during a read access.
    always_comb begin
        PRDATA = 32'd0;
        if (rd_s) begin
            case (addr_s)
                12'h000: PRDATA = mask64_s[31:0];
                12'h004: PRDATA = mask64_s[63:32];
                12'h008: PRDATA = empty_s ? 32'd0 : {1'b1, 24'd0, head_s};
                12'h00C: PRDATA = {9'd0, 7'(count_r), 6'd0, full_s, empty_s, 7'd0, overflow_r};
                12'h010: PRDATA = pend64_s[31:0];
                12'h014: PRDATA = pend64_s[63:32];
                12'h018: PRDATA = {31'd0, enable_r};
                default: PRDATA = 32'd0;
            endcase
        end else begin
            PRDATA = 32'd0;
        end
    end

    // Register state, FIFO and interrupt; flush overrides queue, pending and scan pointer.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            mask_r     <= {N_GPIO{1'b0}};
            pending_r  <= {N_GPIO{1'b0}};
            int_q_r    <= {N_GPIO{1'b0}};
            enable_r   <= 1'b0;
            overflow_r <= 1'b0;
            irq_r      <= 1'b0;
            rr_ptr_r   <= 7'd0;
            wr_ptr_r   <= {AW{1'b0}};
            rd_ptr_r   <= {AW{1'b0}};
            count_r    <= {CW{1'b0}};
        end else begin
            int_q_r <= interrupt_i;
            irq_r   <= enable_r & ~empty_s;
            if (mask_wr_s) begin
                mask_r <= new_mask64_s[N_GPIO-1:0];
            end
            if (wr_s && (addr_s == 12'h018)) begin
                enable_r <= PWDATA[0];
            end
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (ovf_clr_s) begin
                overflow_r <= 1'b0;
            end
            if (flush_s) begin
                pending_r <= {N_GPIO{1'b0}};
                rr_ptr_r  <= 7'd0;
                wr_ptr_r  <= {AW{1'b0}};
                rd_ptr_r  <= {AW{1'b0}};
                count_r   <= {CW{1'b0}};
            end else begin
                pending_r <= pending_n_s;
                if (push_s) begin
                    fifo_mem_r[wr_ptr_r] <= sel_s;
                    wr_ptr_r             <= wr_ptr_r + AW'(1);
                    rr_ptr_r             <= rr_next_s;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + AW'(1);
                end
                case ({push_s, pop_s})
                    2'b10:   count_r <= count_r + CW'(1);
                    2'b01:   count_r <= count_r - CW'(1);
                    default: count_r <= count_r;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_apb_gpio_irq_queue.sv
// Self-checking bench: behavioural queue model checked every cycle, plus
// directed scenarios with hand-computed expectations and a randomized phase.
module tb_apb_gpio_irq_queue;
    localparam int N     = 32;
    localparam int DEPTH = 8;

    logic          HCLK = 1'b0;
    logic          HRESET, PWRITE, PSEL, PENABLE;
    logic [11:0]   PADDR;
    logic [31:0]   PWDATA, PRDATA;
    logic          PREADY, PSLVERR, irq_o;
    logic [N-1:0]  interrupt_i;

    apb_gpio_irq_queue #(.APB_ADDR_WIDTH(12), .N_GPIO(N), .FIFO_DEPTH(DEPTH)) dut (
        .HCLK(HCLK), .HRESET(HRESET), .PADDR(PADDR), .PWDATA(PWDATA),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
        .PREADY(PREADY), .PSLVERR(PSLVERR), .interrupt_i(interrupt_i), .irq_o(irq_o)
    );

    always #5 HCLK = ~HCLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [63:0] m_mask, m_pend, m_intq;
    int          m_q[$];
    bit          m_ovf, m_en, m_irq;
    int          m_rr;
    bit          chk_en = 1'b0;

    function automatic logic [31:0] exp_rd(input logic [11:0] a);
        int sz;
        sz = m_q.size();
        case (a)
            12'h000: return m_mask[31:0];
            12'h004: return m_mask[63:32];
            12'h008: return (sz > 0) ? (32'h8000_0000 | 32'(m_q[0])) : 32'd0;
            12'h00C: return (32'(sz) << 16) | (32'(sz == DEPTH) << 9) |
                            (32'(sz == 0) << 8) | 32'(m_ovf);
            12'h010: return m_pend[31:0];
            12'h014: return m_pend[63:32];
            12'h018: return 32'(m_en);
            default: return 32'd0;
        endcase
    endfunction

    // Model step at every clock edge, from the pre-edge state and the inputs.
    always @(posedge HCLK) begin
        logic [63:0] edg, pv, wm;
        bit acc, pop, push, flush, ovf_evt;
        int sel, sz, p;
        logic [11:0] a;
        if (HRESET) begin
            m_mask = 64'd0; m_pend = 64'd0; m_intq = 64'd0; m_rr = 0;
            m_q.delete(); m_ovf = 1'b0; m_en = 1'b0; m_irq = 1'b0; chk_en = 1'b1;
        end else begin
            acc = PSEL && PENABLE;
            a   = PADDR;
            edg = 64'd0;
            for (int i = 0; i < N; i++) edg[i] = interrupt_i[i] & ~m_intq[i] & m_mask[i];
            sz   = m_q.size();
            pop  = acc && !PWRITE && a == 12'h008 && sz > 0;
            push = 1'b0; sel = 0;
            if (sz < DEPTH) begin
                for (int j = 0; j < N; j++) begin
                    p = (m_rr + j) % N;
                    if (!push && m_pend[p]) begin push = 1'b1; sel = p; end
                end
            end
            flush = acc && PWRITE && a == 12'h018 && PWDATA[1];
            m_irq = m_en && (sz != 0);
            ovf_evt = 1'b0;
            for (int i = 0; i < N; i++)
                if (edg[i] && m_pend[i] && !(push && sel == i)) ovf_evt = 1'b1;
            if (acc && PWRITE && a == 12'h00C && PWDATA[0]) m_ovf = 1'b0;
            if (ovf_evt) m_ovf = 1'b1;
            pv = m_pend;
            if (push) pv[sel] = 1'b0;
            pv = pv | edg;
            wm = m_mask;
            if (acc && PWRITE && a == 12'h000) wm[31:0]  = PWDATA;
            if (acc && PWRITE && a == 12'h004) wm[63:32] = PWDATA;
            for (int i = N; i < 64; i++) wm[i] = 1'b0;
            pv = pv & wm;
            m_mask = wm;
            if (acc && PWRITE && a == 12'h018) m_en = PWDATA[0];
            if (pop) void'(m_q.pop_front());
            if (push) begin m_q.push_back(sel); m_rr = (sel + 1) % N; end
            if (flush) begin m_q.delete(); pv = 64'd0; m_rr = 0; end
            m_pend = pv;
            m_intq = 64'(interrupt_i);
        end
    end

    // Compare process: outputs against the model every cycle, away from the edge.
    always @(negedge HCLK) begin
        #3;
        if (chk_en) begin
            chk("irq_o", 32'(irq_o), 32'(m_irq));
            chk("PREADY", 32'(PREADY), 32'd1);
            chk("PSLVERR", 32'(PSLVERR), 32'd0);
            chk("PRDATA", PRDATA, (PSEL && PENABLE && !PWRITE) ? exp_rd(PADDR) : 32'd0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge HCLK);
    endtask

    task automatic apb_wr(input logic [11:0] a, input logic [31:0] dv);
        PADDR = a; PWDATA = dv; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_rd(input logic [11:0] a, output logic [31:0] dv);
        PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge HCLK);
        PENABLE = 1'b1;
        #3 dv = PRDATA;
        @(negedge HCLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    logic [31:0] d;
    int          got;
    logic [11:0] addrs [10] = '{12'h000, 12'h004, 12'h008, 12'h008, 12'h008,
                                12'h00C, 12'h010, 12'h014, 12'h018, 12'h01C};
    logic [11:0] bad_addrs [4] = '{12'h01C, 12'h020, 12'hFFC, 12'h002};

    initial begin
        HRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = 12'd0; PWDATA = 32'd0; interrupt_i = '0;
        repeat (3) @(negedge HCLK);
        HRESET = 1'b0;
        #3 chk("reset_irq", 32'(irq_o), 32'd0);
        chk("reset_prdata", PRDATA, 32'd0);
        @(negedge HCLK);
        apb_rd(12'h00C, d); chk("reset_status", d, 32'h0000_0100);

        // single pin 0 event with latency checks
        apb_wr(12'h018, 32'h1);
        apb_wr(12'h000, 32'h1);
        interrupt_i[0] = 1'b1;
        apb_rd(12'h010, d); chk("pending0_after_edge", d, 32'h1);
        interrupt_i[0] = 1'b0;
        #3 chk("irq_low_at_k1", 32'(irq_o), 32'd0);
        @(negedge HCLK);
        #3 chk("irq_high_at_k2", 32'(irq_o), 32'd1);
        @(negedge HCLK);
        apb_rd(12'h008, d); chk("pop_pin0", d, 32'h8000_0000);
        idle(3);

        // round robin starting at rr_ptr=2
        apb_wr(12'h000, 32'hF);
        interrupt_i = 32'h2; idle(1); interrupt_i = '0; idle(4);
        apb_rd(12'h008, d); chk("pop_pin1", d, 32'h8000_0001);
        interrupt_i = 32'hE; idle(1); interrupt_i = '0; idle(6);
        apb_rd(12'h008, d); chk("rr_pop_a", d, 32'h8000_0002);
        apb_rd(12'h008, d); chk("rr_pop_b", d, 32'h8000_0003);
        apb_rd(12'h008, d); chk("rr_pop_c", d, 32'h8000_0001);
        apb_rd(12'h008, d); chk("rr_pop_empty", d, 32'h0);

        // ten pins into an eight-deep FIFO
        apb_wr(12'h000, 32'h3FF0);
        interrupt_i = 32'h3FF0; idle(1); interrupt_i = '0; idle(12);
        apb_rd(12'h00C, d); chk("full_status", d, 32'h0008_0200);
        apb_rd(12'h010, d); chk("full_pending_bits", 32'($countones(d)), 32'd2);
        got = 0;
        for (int i = 0; i < 12; i++) begin
            apb_rd(12'h008, d);
            if (d[31]) got++;
        end
        chk("ten_ids_read", 32'(got), 32'd10);
        apb_rd(12'h00C, d); chk("after_drain_status", d, 32'h0000_0100);

        // overflow on pin 5 while FIFO is full
        apb_wr(12'h000, 32'h3FE0);
        interrupt_i = 32'h3FC0; idle(1); interrupt_i = '0; idle(10);
        interrupt_i = 32'h20; idle(1); interrupt_i = '0; idle(2);
        interrupt_i = 32'h20; idle(1); interrupt_i = '0; idle(2);
        apb_rd(12'h00C, d); chk("overflow_set", d, 32'h0008_0201);
        apb_wr(12'h00C, 32'h1);
        apb_rd(12'h00C, d); chk("overflow_clr", d, 32'h0008_0200);
        got = 0;
        for (int i = 0; i < 12; i++) begin
            apb_rd(12'h008, d);
            if (d[31]) got++;
        end
        chk("ovf_drain_ids", 32'(got), 32'd9);

        // pin 0 edge in the same cycle as its push
        apb_wr(12'h000, 32'hFF1);
        interrupt_i = 32'hFF0; idle(1); interrupt_i = '0; idle(10);
        interrupt_i = 32'h1; idle(1); interrupt_i = '0; idle(2);
        apb_rd(12'h008, d);
        interrupt_i = 32'h1; idle(1); interrupt_i = '0;
        got = 0;
        for (int i = 0; i < 14; i++) begin
            apb_rd(12'h008, d);
            if (d == 32'h8000_0000) got++;
        end
        chk("pin0_two_entries", 32'(got), 32'd2);
        apb_rd(12'h00C, d); chk("pin0_no_overflow", d, 32'h0000_0100);

        // flush, then reset mid-queue
        apb_wr(12'h000, 32'h70);
        interrupt_i = 32'h70; idle(1); interrupt_i = '0; idle(5);
        apb_wr(12'h018, 32'h3);
        apb_rd(12'h00C, d); chk("flush_status", d, 32'h0000_0100);
        apb_rd(12'h010, d); chk("flush_pending", d, 32'h0);
        apb_rd(12'h000, d); chk("flush_mask_kept", d, 32'h70);
        apb_rd(12'h018, d); chk("flush_ctrl", d, 32'h1);
        interrupt_i = 32'h70; idle(1); interrupt_i = '0; idle(5);
        HRESET = 1'b1; idle(1); HRESET = 1'b0;
        apb_rd(12'h00C, d); chk("rst_status", d, 32'h0000_0100);
        apb_rd(12'h000, d); chk("rst_mask", d, 32'h0);
        apb_rd(12'h018, d); chk("rst_ctrl", d, 32'h0);

        // randomized phase
        apb_wr(12'h018, 32'h1);
        apb_wr(12'h000, 32'hFFF);
        for (int it = 0; it < 600; it++) begin
            int r;
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 2) == 0)
                interrupt_i = interrupt_i ^ (32'd1 << $urandom_range(0, 11));
            if ($urandom_range(0, 15) == 0)
                interrupt_i = interrupt_i ^ ($urandom & 32'hFFF);
            if (r < 40) begin
                apb_rd(addrs[$urandom_range(0, 9)], d);
            end else if (r < 50) begin
                apb_wr(12'h000, ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'hFFF));
            end else if (r < 53) begin
                apb_wr(12'h004, $urandom);
            end else if (r < 60) begin
                apb_wr(12'h018, {30'd0, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 5) != 0)});
            end else if (r < 64) begin
                apb_wr(12'h00C, $urandom);
            end else if (r < 68) begin
                apb_wr(bad_addrs[$urandom_range(0, 3)], $urandom);
            end else if (r < 69) begin
                HRESET = 1'b1; idle(1); HRESET = 1'b0;
                apb_wr(12'h018, 32'h1);
                apb_wr(12'h000, 32'hFFF);
            end else begin
                idle($urandom_range(1, 3));
            end
        end
        idle(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
